// File: rtl/cpu_timer_pkg.sv
// cpu_timer shared types: FSM states, register word offsets, CTRL bit layout and mode codes.
package cpu_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode,
                                            input logic im);
    return {28'd0, im, mode, en};
  endfunction

endpackage

// File: rtl/cpu_timer_if.sv
// Bridge-side data bus of the timer: decode hit, word offset, full-word write, read data.
interface cpu_timer_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, we, wdata, input rdata);
  modport slave  (input sel, addr, we, wdata, output rdata);
endinterface

// File: rtl/cpu_timer.sv
// Countdown timer at 0x7f00-0x7f0b: 1-cycle registered reads, 0-cycle writes, never stalls the bus.
// Auto-reload mode exists only when CPU_TIMER_AUTORELOAD_EN is defined; otherwise MODE is forced to one-shot.
module cpu_timer
  import cpu_timer_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  cpu_timer_if.slave    bus,
  output logic          irq
);

  state_e      state_q, state_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic        ctrl_im_q, ctrl_im_d;
  logic [1:0]  ctrl_mode;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        int_flag_q, int_flag_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ctrl_wr, preset_wr, rd_en, auto_mode;

  assign ctrl_wr   = bus.sel & bus.we & (bus.addr == ADDR_CTRL);
  assign preset_wr = bus.sel & bus.we & (bus.addr == ADDR_PRESET);
  assign rd_en     = bus.sel & ~bus.we;

`ifdef CPU_TIMER_AUTORELOAD_EN
  logic [1:0] ctrl_mode_q, ctrl_mode_d;
  assign ctrl_mode_d = ctrl_wr ? bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB] : ctrl_mode_q;
  assign ctrl_mode   = ctrl_mode_q;
  assign auto_mode   = (ctrl_mode_q == MODE_RELOAD);
`else
  assign ctrl_mode   = MODE_ONESHOT;
  assign auto_mode   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ctrl_en_d  = ctrl_en_q;
    ctrl_im_d  = ctrl_im_q;
    count_d    = count_q;
    int_flag_d = int_flag_q;
    preset_d   = preset_wr ? bus.wdata : preset_q;

    if (ctrl_wr) begin
      ctrl_en_d  = bus.wdata[CTRL_EN_BIT];
      ctrl_im_d  = bus.wdata[CTRL_IM_BIT];
      int_flag_d = 1'b0;
    end

    // CNT decides on the EN being written this edge so a racing disable wins over expiry.
    unique case (state_q)
      ST_IDLE: if (ctrl_en_q) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en_d) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          int_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (auto_mode)     int_flag_d = 1'b0;
        else if (!ctrl_wr) ctrl_en_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    irq_d = ctrl_im_d & int_flag_d;

    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (bus.addr)
        ADDR_CTRL:   rdata_d = ctrl_word(ctrl_en_q, ctrl_mode, ctrl_im_q);
        ADDR_PRESET: rdata_d = preset_q;
        ADDR_COUNT:  rdata_d = count_q;
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ctrl_en_q   <= 1'b0;
      ctrl_im_q   <= 1'b0;
      preset_q    <= RESET_PRESET;
      count_q     <= 32'd0;
      int_flag_q  <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= 32'd0;
`ifdef CPU_TIMER_AUTORELOAD_EN
      ctrl_mode_q <= MODE_ONESHOT;
`endif
    end else begin
      state_q     <= state_d;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_im_q   <= ctrl_im_d;
      preset_q    <= preset_d;
      count_q     <= count_d;
      int_flag_q  <= int_flag_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
`ifdef CPU_TIMER_AUTORELOAD_EN
      ctrl_mode_q <= ctrl_mode_d;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule
